multiword_adder: RTL and testbench
==================================

# multiword_adder

Multi-cycle wide adder that feeds an N-bit ripple carry adder slice one N-bit word per cycle, with a registered carry between slices, to add two W = N*WORDS bit operands. Sits upstream of and wraps the existing `RCA` slice: it sequences operand words into the slice, captures each slice sum, and chains the slice carry through a register. It trades latency for area where a full-width combinational adder would be too large or too slow.

## Interface
- `N`, 16: slice width in bits; passed to the `RCA` instance.
- `WORDS`, 4: number of slices; `WORDS` >= 1; total width W = N*WORDS.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on `clk`, accepted only in IDLE or DONE.
- `a`  in  W  operand A; captured on accepted start.
- `b`  in  W  operand B; captured on accepted start.
- `carry_in`  in  1  carry into slice 0; captured on accepted start.
- `busy`  out  1  high while slices are being added.
- `done`  out  1  one-cycle pulse: `sum` and `carry_out` are valid.
- `sum`  out  W  registered result.
- `carry_out`  out  1  registered carry out of slice WORDS-1.

## Operation
- State machine:
  - IDLE: `busy` = 0, `done` = 0.
    - IDLE -> RUN on `start`: latch `a`, `b` and `carry_in` into the operand and carry registers; slice index `idx` = 0.
  - RUN: `busy` = 1. Each cycle:
    - Drive the `RCA` with `a_reg[idx*N +: N]`, `b_reg[idx*N +: N]` and `carry_reg`.
    - On the edge, write the slice sum into `sum[idx*N +: N]` and load `carry_reg` from the slice `carry_out`.
    - If `idx` != WORDS-1, increment `idx`. If `idx` == WORDS-1, also load `carry_out` and go to DONE.
  - DONE: `done` = 1 for exactly one cycle, `busy` = 0.
    - DONE -> RUN if `start` (back-to-back operation, same capture as IDLE).
    - DONE -> IDLE otherwise.
- Output hold and validity:
  - `sum` and `carry_out` hold their values after DONE until the next accepted start.
  - During RUN, `sum` is updated progressively and is not valid.
- Arithmetic: {`carry_out`, `sum`} = `a` + `b` + `carry_in`, exact, modulo 2^(W+1). No signed interpretation and no overflow flag.
- `start` while in RUN is ignored. Operands captured at the accepted start are used unchanged; later changes on `a`/`b` have no effect.
- `start` held high continuously: a new operation starts in every DONE cycle.
- WORDS = 1: RUN lasts one cycle; the behaviour otherwise matches WORDS > 1.
- Reset (asynchronous, at any time including mid-RUN):
  - State -> IDLE; `idx`, operand and carry registers -> 0.
  - Outputs: `busy` = 0, `done` = 0, `sum` = 0, `carry_out` = 0.
  - The in-flight operation is discarded; no `done` is produced for it.

## Timing
- Start accepted at edge E0. `busy` = 1 in cycles E0..E0+WORDS-1, i.e. it falls at edge E0+WORDS.
- `done` = 1 in the cycle after edge E0+WORDS; latency is WORDS+1 edges from the start edge to the `done` cycle.
- Throughput: one result per WORDS+1 cycles with back-to-back starts.
- Critical path: one N-bit ripple through `RCA` plus the slice mux. No combinational path from `start`, `a` or `b` to any output.

## Structure
- Shared package holds:
  - State encoding constants `ST_IDLE`, `ST_RUN`, `ST_DONE` (2 bits).
  - Width helper for `idx`: clog2(WORDS), minimum 1.
- One sub-module: the existing `RCA` (parameter `N`) instantiated once as the slice datapath. All sequencing, muxing and registers live in `multiword_adder`.

## Test plan
- N=16, WORDS=4: `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=0x1, `carry_in`=0 -> `sum`=0x0, `carry_out`=1. `done` appears 5 edges after the start edge and `busy` is high for 4 cycles.
- `a`=0x0123_4567_89AB_CDEF, `b`=0x1111_1111_1111_1111, `carry_in`=1 -> `sum`=0x1234_5678_9ABC_DF01, `carry_out`=0.
- Start with `a`=5, `b`=7; pulse `start` again with `a`=0xFFFF, `b`=0xFFFF two cycles later; change `a`/`b` during RUN -> the second start is ignored, `sum`=12 with a single `done`, and no `done` follows for the second request.
- Assert `rst` in the second RUN cycle -> all outputs 0 immediately and no `done`. After release, start `a`=1, `b`=2 -> `sum`=3 after 5 edges.
- `start` held high for 12 cycles with constant operands 3 and 4 -> `done` pulses every 5 cycles and `sum`=7 each time.
- WORDS=1, N=8: `a`=0xFF, `b`=0x01, `carry_in`=1 -> `sum`=0x01, `carry_out`=1, `done` 2 edges after start.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// Shared state encoding and sizing helpers for the word-serial wide adder.
package multiword_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slice index width; a single-slice adder still needs a 1-bit index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_adder_if.sv
// Request/result bundle of the word-serial adder; master issues operands, slave computes.
interface multiword_adder_if #(
  parameter int N     = 16,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/multiword_adder_rca.sv
// N-bit ripple carry adder slice; purely combinational, one carry chain.
module RCA #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  logic cy;

  always_comb begin
    cy  = carry_in;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    carry_out = cy;
  end
endmodule

// File: rtl/multiword_adder.sv
// Wide adder that streams one N-bit word per cycle through a single RCA slice.
// Result pulses done WORDS+1 edges after the accepted start; start is ignored while busy.
module multiword_adder
  import multiword_adder_pkg::*;
#(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input logic              clk,
  input logic              rst,
  multiword_adder_if.slave bus
);
  localparam int            W        = N * WORDS;
  localparam int            IW       = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry_reg;
  logic          cout_reg;
  logic          accept;
  logic          last;

  logic [N-1:0]  slice_a;
  logic [N-1:0]  slice_b;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;

  assign last    = (idx == LAST_IDX);
  assign slice_a = a_reg[idx*N +: N];
  assign slice_b = b_reg[idx*N +: N];

  RCA #(.N(N)) u_rca (
    .a         (slice_a),
    .b         (slice_b),
    .carry_in  (carry_reg),
    .sum       (slice_sum),
    .carry_out (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE accepts a new start exactly like IDLE so back-to-back ops lose no cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      carry_reg <= bus.carry_in;
    end else if (state == ST_RUN) begin
      sum_reg[idx*N +: N] <= slice_sum;
      carry_reg           <= slice_cout;
      if (last) begin
        cout_reg <= slice_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.busy      = (state == ST_RUN);
  assign bus.done      = (state == ST_DONE);
  assign bus.sum       = sum_reg;
  assign bus.carry_out = cout_reg;
endmodule

// File: tb/tb_multiword_adder.sv
// Scoreboard bench: drivers queue exact-arithmetic results, monitors compare on each done pulse.
module tb_multiword_adder;
  localparam int N      = 16;
  localparam int WORDS  = 4;
  localparam int W      = N * WORDS;
  localparam int N1     = 8;
  localparam int WORDS1 = 1;
  localparam int W1     = N1 * WORDS1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiword_adder_if #(.N(N),  .WORDS(WORDS))  bus  ();
  multiword_adder_if #(.N(N1), .WORDS(WORDS1)) bus1 ();

  multiword_adder #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multiword_adder #(.N(N1), .WORDS(WORDS1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           done_cyc;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   busy_cnt = 0;
  int   busy_cnt1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < (W + 31) / 32; i++) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  // Main DUT monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", {{W{1'b0}}, bus.done}, '0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", {1'b0, bus.sum}, {1'b0, e.sum});
          chk("carry_out", {{W{1'b0}}, bus.carry_out}, {{W{1'b0}}, e.cout});
          chk("done_cycle", (W+1)'(cyc), (W+1)'(e.done_cyc));
          chk("busy_cycles", (W+1)'(busy_cnt), (W+1)'(WORDS));
        end
        busy_cnt = 0;
      end
    end
  end

  // Single-slice DUT monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_cnt1 = 0;
    end else begin
      if (bus1.busy) busy_cnt1++;
      if (bus1.done) begin
        if (q1.size() == 0) begin
          chk("w1_spurious_done", {{W{1'b0}}, bus1.done}, '0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("w1_sum", (W+1)'(bus1.sum), (W+1)'(e.sum[W1-1:0]));
          chk("w1_carry_out", {{W{1'b0}}, bus1.carry_out}, {{W{1'b0}}, e.cout});
          chk("w1_done_cycle", (W+1)'(cyc), (W+1)'(e.done_cyc));
          chk("w1_busy_cycles", (W+1)'(busy_cnt1), (W+1)'(WORDS1));
        end
        busy_cnt1 = 0;
      end
    end
  end

  // Called at a negedge while the DUT is in IDLE or DONE; returns at the DONE-cycle negedge plus gap.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cin, input int gap);
    logic [W:0] r;
    exp_t       e;
    r = {1'b0, av} + {1'b0, bv} + (W+1)'(cin);
    e.sum = r[W-1:0];
    e.cout = r[W];
    e.done_cyc = cyc + 1 + WORDS;
    q.push_back(e);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.carry_in = cin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = rnd_w();
    bus.b = rnd_w();
    bus.carry_in = ~cin;
    repeat (WORDS) @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_op1(input logic [W1-1:0] av, input logic [W1-1:0] bv, input logic cin, input int gap);
    logic [W1:0] r;
    exp_t        e;
    r = {1'b0, av} + {1'b0, bv} + (W1+1)'(cin);
    e.sum = W'(r[W1-1:0]);
    e.cout = r[W1];
    e.done_cyc = cyc + 1 + WORDS1;
    q1.push_back(e);
    bus1.start = 1'b1;
    bus1.a = av;
    bus1.b = bv;
    bus1.carry_in = cin;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.a = W1'($urandom);
    bus1.b = W1'($urandom);
    bus1.carry_in = ~cin;
    repeat (WORDS1) @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.carry_in = 1'b0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {{W{1'b0}}, bus.busy}, '0);
    chk("reset_done", {{W{1'b0}}, bus.done}, '0);
    chk("reset_sum", {1'b0, bus.sum}, '0);
    chk("reset_carry_out", {{W{1'b0}}, bus.carry_out}, '0);
    chk("w1_reset_sum", (W+1)'(bus1.sum), '0);
    rst = 1'b0;
    @(negedge clk);

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1);
    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1);
    do_op('0, '0, 1'b0, 0);
    do_op('1, '1, 1'b1, 2);

    // A second start two cycles into RUN must be dropped and operand changes ignored.
    begin
      exp_t e;
      e.sum = 64'd12;
      e.cout = 1'b0;
      e.done_cyc = cyc + 1 + WORDS;
      q.push_back(e);
      bus.start = 1'b1;
      bus.a = 64'd5;
      bus.b = 64'd7;
      bus.carry_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 64'hFFFF;
      bus.b = 64'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = rnd_w();
      bus.b = rnd_w();
      repeat (WORDS - 2) @(negedge clk);
      repeat (WORDS + 2) @(negedge clk);
    end

    // Reset in the second RUN cycle discards the operation.
    bus.start = 1'b1;
    bus.a = rnd_w();
    bus.b = rnd_w();
    bus.carry_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {{W{1'b0}}, bus.busy}, '0);
    chk("midrun_rst_done", {{W{1'b0}}, bus.done}, '0);
    chk("midrun_rst_sum", {1'b0, bus.sum}, '0);
    chk("midrun_rst_carry_out", {{W{1'b0}}, bus.carry_out}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(64'd1, 64'd2, 1'b0, 2);

    // start held high for 12 edges: a new op is accepted in every DONE cycle.
    bus.start = 1'b1;
    bus.a = 64'd3;
    bus.b = 64'd4;
    bus.carry_in = 1'b0;
    for (int i = 0; 1 + i * (WORDS + 1) <= 12; i++) begin
      exp_t e;
      e.sum = 64'd7;
      e.cout = 1'b0;
      e.done_cyc = cyc + 1 + WORDS + i * (WORDS + 1);
      q.push_back(e);
    end
    repeat (12) @(negedge clk);
    bus.start = 1'b0;
    repeat (WORDS + 2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      do_op(rnd_w(), rnd_w(), 1'($urandom), int'($urandom_range(0, 2)));
    end

    do_op1(8'hFF, 8'h01, 1'b1, 1);
    do_op1(8'h00, 8'h00, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      do_op1(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (10) @(negedge clk);
    chk("pending_results", (W+1)'(q.size()), '0);
    chk("w1_pending_results", (W+1)'(q1.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
